regwrite_arbiter: RTL



---
 rtl/regwrite_arbiter_pkg.sv | 17 +
 rtl/regwrite_arbiter_if.sv | 41 ++++
 rtl/regwrite_arbiter_rr_pick2.sv | 20 ++
 rtl/regwrite_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/regwrite_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// bus widths, arbiter state encoding and destination-mux select values.
package regwrite_arbiter_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ARB,
      OWN0,
      OWN1
   } arb_state_t;

   localparam logic SEL_REQ0 = 1'b0;
   localparam logic SEL_REQ1 = 1'b1;

endpackage

// File: rtl/regwrite_arbiter_if.sv
// Writeback bus: two requesters (ALU/rd and load/rt) plus the registered
// register-file write port and destination-address mux select.
interface regwrite_arbiter_if
   import regwrite_arbiter_pkg::*;
#(
   parameter int AW = ADDR_W,
   parameter int DW = DATA_W
);

   logic          req0_valid;
   logic          req0_lock;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_data;
   logic          req0_ready;

   logic          req1_valid;
   logic          req1_lock;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_data;
   logic          req1_ready;

   logic          mux_sel;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   modport master (
      output req0_valid, req0_lock, req0_addr, req0_data,
      output req1_valid, req1_lock, req1_addr, req1_data,
      input  req0_ready, req1_ready,
      input  mux_sel, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  req0_valid, req0_lock, req0_addr, req0_data,
      input  req1_valid, req1_lock, req1_addr, req1_data,
      output req0_ready, req1_ready,
      output mux_sel, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/regwrite_arbiter_rr_pick2.sv
// Combinational two-way round-robin chooser: a lone requester always wins,
// a tie goes to the requester that was not granted last.
module rr_pick2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      // NOTE: default first so every path assigns grant and no latch is inferred.
      grant = 2'b00;
      unique case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/regwrite_arbiter.sv
// Shares the register-file write port between the ALU and load writeback
// paths: round-robin with capped locked bursts and a registered output stage.
module regwrite_arbiter
   import regwrite_arbiter_pkg::*;
#(
   parameter int DATA_W      = regwrite_arbiter_pkg::DATA_W,
   parameter int ADDR_W      = regwrite_arbiter_pkg::ADDR_W,
   parameter int MAX_BURST   = 4,
   parameter bit ZERO_REG_RO = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   regwrite_arbiter_if.slave   bus
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BURST);

   arb_state_t         state;
   logic               rr_last;
   logic [CNT_W-1:0]   burst_cnt;
   logic [CNT_W-1:0]   cnt_next;

   logic [1:0]         pick;
   logic [1:0]         grant;
   logic               own_hold;
   logic               g_idx;
   logic               g_lock;
   logic [ADDR_W-1:0]  g_addr;
   logic [DATA_W-1:0]  g_data;

   rr_pick2 u_pick (
      .valid ({bus.req1_valid, bus.req0_valid}),
      .last  (rr_last),
      .grant (pick)
   );

   // An owner that keeps its valid high shuts out the other side; once it
   // drops valid the cycle falls straight back to plain round-robin.
   always_comb begin
      grant    = 2'b00;
      own_hold = 1'b0;
      if (!reset && !flush) begin
         if (state == OWN0 && bus.req0_valid) begin
            grant    = 2'b01;
            own_hold = 1'b1;
         end else if (state == OWN1 && bus.req1_valid) begin
            grant    = 2'b10;
            own_hold = 1'b1;
         end else begin
            grant = pick;
         end
      end
   end

   assign bus.req0_ready = grant[0];
   assign bus.req1_ready = grant[1];

   assign g_idx    = grant[1];
   assign g_lock   = g_idx ? bus.req1_lock : bus.req0_lock;
   assign g_addr   = g_idx ? bus.req1_addr : bus.req0_addr;
   assign g_data   = g_idx ? bus.req1_data : bus.req0_data;
   assign cnt_next = burst_cnt + 1'b1;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state       <= ARB;
         rr_last     <= 1'b1;
         burst_cnt   <= '0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         bus.mux_sel <= SEL_REQ0;
      end else begin
         // Writes to r0 are swallowed: the beat retires but never reaches the port.
         bus.wr_en <= (|grant) && !(ZERO_REG_RO && (g_addr == '0));

         if (|grant) begin
            bus.wr_addr <= g_addr;
            bus.wr_data <= g_data;
            bus.mux_sel <= g_idx ? SEL_REQ1 : SEL_REQ0;
            rr_last     <= g_idx;
         end

         if (!(|grant)) begin
            state     <= ARB;
            burst_cnt <= '0;
         end else if (own_hold) begin
            if (!g_lock || cnt_next == CNT_CAP) begin
               state     <= ARB;
               burst_cnt <= '0;
            end else begin
               burst_cnt <= cnt_next;
            end
         end else if (g_lock && MAX_BURST > 1) begin
            state     <= g_idx ? OWN1 : OWN0;
            burst_cnt <= CNT_W'(1);
         end else begin
            state     <= ARB;
            burst_cnt <= '0;
         end
      end
   end

endmodule
